muldiv_ctrl: RTL

- Sequencing controller between the pipeline's EX stage and the multi-cycle multiplier and divider.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO one at a time and owns the HI/LO architectural registers.
- Drives the start/operand handshake to whichever unit is needed, holds operands stable until that unit finishes, and back-pressures the pipeline while busy.
- Handles flush, divide-by-zero and a missing-finish watchdog.

---
 rtl/muldiv_ctrl_if.sv | 21 ++
 rtl/muldiv_ctrl.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl_if.sv
// Pipeline-side operation bus of the mul/div sequencer: op request, flush and MF read-back.
interface muldiv_ctrl_if;
    logic        op_valid;
    logic [2:0]  op_code;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        op_ready;
    logic        flush;
    logic        rd_valid;
    logic [31:0] rd_data;

    modport master (
        output op_valid, op_code, op_a, op_b, flush,
        input  op_ready, rd_valid, rd_data
    );

    modport slave (
        input  op_valid, op_code, op_a, op_b, flush,
        output op_ready, rd_valid, rd_data
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// Sequences MULT/DIV/MT/MF between EX and the multi-cycle units; owns HI/LO, handles flush,
// divide-by-zero suppression and a missing-finish watchdog.
module muldiv_ctrl #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_ctrl_if.slave op,
    output logic [31:0]  hi,
    output logic [31:0]  lo,
    output logic         err,
    output logic         mul_start,
    output logic         mul_ena,
    output logic         mul_signed,
    output logic [31:0]  mul_a,
    output logic [31:0]  mul_b,
    input  logic         mul_finish,
    input  logic [63:0]  mul_z,
    output logic         div_start,
    output logic         div_signed,
    output logic [31:0]  div_a,
    output logic [31:0]  div_b,
    input  logic         div_finish,
    input  logic [31:0]  div_q,
    input  logic [31:0]  div_r
);
    localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN, DRAIN} state_t;

    state_t        state, state_next;
    logic          first;
    logic          unit_div;
    logic [CW-1:0] wd_cnt;
    logic          accept, ld_mul, ld_div, wr_hi, wr_lo, rd_req;
    logic          commit_mul, commit_div, set_err;
    logic          unit_finish, wd_hit;

    assign unit_finish = unit_div ? div_finish : mul_finish;
    assign wd_hit      = (wd_cnt == CW'(TIMEOUT - 1));

    always_comb begin
        state_next  = state;
        accept      = (state == IDLE) && op.op_valid && !op.flush;
        ld_mul      = 1'b0;
        ld_div      = 1'b0;
        wr_hi       = 1'b0;
        wr_lo       = 1'b0;
        rd_req      = 1'b0;
        commit_mul  = 1'b0;
        commit_div  = 1'b0;
        set_err     = 1'b0;
        op.op_ready = (state == IDLE);
        mul_start   = (state == MUL_RUN) && first;
        div_start   = (state == DIV_RUN) && first;
        // DRAIN keeps the multiplier enabled so it can still produce its (discarded) finish
        mul_ena     = (state == MUL_RUN) || ((state == DRAIN) && !unit_div);
        case (state)
            IDLE: begin
                if (accept) begin
                    case (op.op_code[2:1])
                        2'b00: begin
                            ld_mul     = 1'b1;
                            state_next = MUL_RUN;
                        end
                        2'b01: begin
                            if (op.op_b != '0) begin
                                ld_div     = 1'b1;
                                state_next = DIV_RUN;
                            end
                        end
                        2'b10: begin
                            wr_hi = !op.op_code[0];
                            wr_lo = op.op_code[0];
                        end
                        default: rd_req = 1'b1;
                    endcase
                end
            end
            MUL_RUN, DIV_RUN: begin
                // flush beats a coincident finish: that finish is consumed and dropped
                if (op.flush) begin
                    state_next = unit_finish ? IDLE : DRAIN;
                end else if (unit_finish) begin
                    commit_mul = (state == MUL_RUN);
                    commit_div = (state == DIV_RUN);
                    state_next = IDLE;
                end else if (wd_hit) begin
                    set_err    = 1'b1;
                    state_next = IDLE;
                end
            end
            DRAIN: begin
                if (unit_finish) begin
                    state_next = IDLE;
                end else if (wd_hit) begin
                    set_err    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            first       <= 1'b0;
            unit_div    <= 1'b0;
            wd_cnt      <= '0;
            hi          <= '0;
            lo          <= '0;
            err         <= 1'b0;
            op.rd_valid <= 1'b0;
            op.rd_data  <= '0;
            mul_a       <= '0;
            mul_b       <= '0;
            mul_signed  <= 1'b0;
            div_a       <= '0;
            div_b       <= '0;
            div_signed  <= 1'b0;
        end else begin
            first       <= (state == IDLE) && (state_next != IDLE);
            op.rd_valid <= rd_req;
            if (state_next != state) wd_cnt <= '0;
            else if (state != IDLE)  wd_cnt <= wd_cnt + CW'(1);
            if (rd_req) op.rd_data <= op.op_code[0] ? lo : hi;
            if (ld_mul) begin
                mul_a      <= op.op_a;
                mul_b      <= op.op_b;
                mul_signed <= ~op.op_code[0];
                unit_div   <= 1'b0;
            end
            if (ld_div) begin
                div_a      <= op.op_a;
                div_b      <= op.op_b;
                div_signed <= ~op.op_code[0];
                unit_div   <= 1'b1;
            end
            if (wr_hi) hi <= op.op_a;
            if (wr_lo) lo <= op.op_a;
            if (commit_mul) {hi, lo} <= mul_z;
            if (commit_div) begin
                hi <= div_r;
                lo <= div_q;
            end
            if (set_err) err <= 1'b1;
        end
    end
endmodule
